// File: rtl/multi_timer_if.sv
// Handshake bundle for the multi-channel countdown timer.
// Controller drives strobes/loads, timer returns status per channel.
interface multi_timer_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 16
);
  logic [NUM_CH-1:0]       start_i;
  logic [NUM_CH-1:0]       stop_i;
  logic [NUM_CH-1:0]       periodic_i;
  logic [NUM_CH*WIDTH-1:0] load_i;
  logic                    pause_i;
  logic [NUM_CH-1:0]       busy_o;
  logic [NUM_CH-1:0]       expired_o;
  logic [NUM_CH-1:0]       tick_o;
  logic [NUM_CH*WIDTH-1:0] count_o;

  modport master (
    output start_i, stop_i, periodic_i, load_i, pause_i,
    input  busy_o, expired_o, tick_o, count_o
  );

  modport slave (
    input  start_i, stop_i, periodic_i, load_i, pause_i,
    output busy_o, expired_o, tick_o, count_o
  );
endinterface

// File: rtl/multi_timer.sv
// Multi-channel countdown timer: runtime loads, one-shot/periodic,
// per-channel prescaler, shared pause, stop/abort.
module multi_timer #(
  parameter int NUM_CH   = 4,
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1
) (
  input  logic         clk,
  input  logic         resetn,
  multi_timer_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [1:0]       r_state [NUM_CH];
  logic [WIDTH-1:0] r_cnt   [NUM_CH];
  logic             r_tick  [NUM_CH];

  genvar n;
  for (n = 0; n < NUM_CH; n++) begin : g_ch
    logic [WIDTH-1:0] w_load;
    logic             w_step;
    logic             w_wrap;
    logic [WIDTH-1:0] r_load;
    logic             r_per;

    assign w_load = bus.load_i[n*WIDTH +: WIDTH];
    assign w_step = (r_state[n] == S_RUN) & ~bus.pause_i
                  & ~bus.start_i[n] & ~bus.stop_i[n];

    if (PRESCALE > 1) begin : g_pre
      localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
      logic [PW-1:0] r_pre;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_pre <= '0;
        end else if (bus.start_i[n] | bus.stop_i[n]) begin
          r_pre <= '0;
        end else if (w_step) begin
          r_pre <= (r_pre == PMAX) ? '0 : r_pre + 1'b1;
        end
      end

      assign w_wrap = (r_pre == PMAX);
    end else begin : g_nopre
      assign w_wrap = 1'b1;
    end

    // stop beats start; start beats a coinciding expiry
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_state[n] <= S_IDLE;
        r_cnt[n]   <= '0;
        r_tick[n]  <= 1'b0;
        r_load     <= '0;
        r_per      <= 1'b0;
      end else begin
        r_tick[n] <= 1'b0;
        if (bus.stop_i[n]) begin
          r_state[n] <= S_IDLE;
          r_cnt[n]   <= '0;
        end else if (bus.start_i[n]) begin
          r_load   <= w_load;
          r_per    <= bus.periodic_i[n];
          r_cnt[n] <= w_load;
          if (w_load == '0) begin
            r_state[n] <= S_DONE;
            r_tick[n]  <= 1'b1;
          end else begin
            r_state[n] <= S_RUN;
          end
        end else if (w_step && w_wrap && r_cnt[n] != '0) begin
          if (r_cnt[n] == WIDTH'(1)) begin
            r_tick[n] <= 1'b1;
            if (r_per) begin
              r_cnt[n] <= r_load;
            end else begin
              r_cnt[n]   <= '0;
              r_state[n] <= S_DONE;
            end
          end else begin
            r_cnt[n] <= r_cnt[n] - 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    bus.busy_o    = '0;
    bus.expired_o = '0;
    bus.tick_o    = '0;
    bus.count_o   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.busy_o[i]    = (r_state[i] == S_RUN);
      bus.expired_o[i] = (r_state[i] != S_RUN);
      bus.tick_o[i]    = r_tick[i];
      bus.count_o[i*WIDTH +: WIDTH] = r_cnt[i];
    end
  end
endmodule
